// File: rtl/btn_reset_req_pkg.sv
// Shared definitions for the push-button debouncer / reset-request block:
// FSM state encodings and the board clock used to size timing parameters.
package btn_reset_req_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE    = 2'd0,
        BTN_WAIT_HI = 2'd1,
        BTN_PRESSED = 2'd2,
        BTN_WAIT_LO = 2'd3
    } btn_state_t;

    localparam int CLK_HZ = 100_000_000;

    // Converts a duration in microseconds to clock cycles at CLK_HZ.
    function automatic int cycles_from_us(input int us);
        return (CLK_HZ / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/btn_reset_req_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on rst.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s0;
    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= d;
            s1 <= s0;
        end
    end

    assign q = s1;

endmodule

// File: rtl/btn_reset_req.sv
// Debounces one raw push-button into level/press/release strobes, flags a long
// press once per press, and stretches that into a registered reset request.
module btn_reset_req
    import btn_reset_req_pkg::*;
#(
    parameter int STABLE_CYCLES = cycles_from_us(10_000),
    parameter int HOLD_CYCLES   = cycles_from_us(2_000_000),
    parameter int REQ_CYCLES    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic long_press,
    output logic rst_req
);

    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int RW = $clog2(REQ_CYCLES) + 1;

    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REQ_LOAD  = RW'(REQ_CYCLES - 1);

    logic s1;

    btn_state_t    state_reg,    state_next;
    logic [SW-1:0] stab_cnt_reg, stab_cnt_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [RW-1:0] req_cnt_reg,  req_cnt_next;
    logic          level_reg,    level_next;
    logic          press_reg,    press_next;
    logic          release_reg,  release_next;
    logic          long_reg,     long_next;
    logic          rst_req_reg,  rst_req_next;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= BTN_IDLE;
            stab_cnt_reg <= '0;
            hold_cnt_reg <= '0;
            req_cnt_reg  <= '0;
            level_reg    <= 1'b0;
            press_reg    <= 1'b0;
            release_reg  <= 1'b0;
            long_reg     <= 1'b0;
            rst_req_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            stab_cnt_reg <= stab_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            req_cnt_reg  <= req_cnt_next;
            level_reg    <= level_next;
            press_reg    <= press_next;
            release_reg  <= release_next;
            long_reg     <= long_next;
            rst_req_reg  <= rst_req_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        stab_cnt_next = stab_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        level_next    = level_reg;
        press_next    = 1'b0;
        release_next  = 1'b0;
        long_next     = 1'b0;

        case (state_reg)
            BTN_IDLE: begin
                if (s1) begin
                    state_next    = BTN_WAIT_HI;
                    stab_cnt_next = '0;
                end
            end
            BTN_WAIT_HI: begin
                if (!s1) begin
                    state_next = BTN_IDLE;
                end else begin
                    stab_cnt_next = stab_cnt_reg + 1'b1;
                    if (stab_cnt_reg == STAB_LAST) begin
                        state_next    = BTN_PRESSED;
                        level_next    = 1'b1;
                        press_next    = 1'b1;
                        hold_cnt_next = '0;
                    end
                end
            end
            BTN_PRESSED: begin
                if (!s1) begin
                    state_next    = BTN_WAIT_LO;
                    stab_cnt_next = '0;
                end else begin
                    // Saturating at HOLD_CYCLES guarantees one long_press per press.
                    if (hold_cnt_reg != HOLD_MAX) begin
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                    end
                    if (hold_cnt_reg == HOLD_LAST) begin
                        long_next = 1'b1;
                    end
                end
            end
            BTN_WAIT_LO: begin
                if (s1) begin
                    // Bounce back high: resume the press, keep hold progress.
                    state_next = BTN_PRESSED;
                end else begin
                    stab_cnt_next = stab_cnt_reg + 1'b1;
                    if (stab_cnt_reg == STAB_LAST) begin
                        state_next   = BTN_IDLE;
                        level_next   = 1'b0;
                        release_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = BTN_IDLE;
            end
        endcase
    end

    // Reset-request stretcher; a long press during an active request is ignored.
    always_comb begin
        req_cnt_next = req_cnt_reg;
        rst_req_next = rst_req_reg;
        if (rst_req_reg) begin
            if (req_cnt_reg == '0) begin
                rst_req_next = 1'b0;
            end else begin
                req_cnt_next = req_cnt_reg - 1'b1;
            end
        end else if (long_reg) begin
            rst_req_next = 1'b1;
            req_cnt_next = REQ_LOAD;
        end
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;
    assign long_press  = long_reg;
    assign rst_req     = rst_req_reg;

endmodule

// File: tb/tb_btn_reset_req.sv
// Directed bench for btn_reset_req: expected strobe cycles are queued as the
// button is driven and matched by a negedge monitor as the DUT emits them.
module tb_btn_reset_req;

    localparam int STABLE = 4;
    localparam int HOLD   = 10;
    localparam int REQ    = 3;
    localparam int LAT    = STABLE + 3;  // drive at negedge -> strobe seen at negedge

    typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG, EV_REQ_ON, EV_REQ_OFF} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic long_press;
    logic rst_req;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic req_prev = 1'b0;
    ev_t  exp_q[$];

    btn_reset_req #(
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD),
        .REQ_CYCLES    (REQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .long_press  (long_press),
        .rst_req     (rst_req)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input ev_kind_t kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input ev_kind_t kind);
        ev_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_%s observed_cyc=%0d expected=none", kind.name(), cyc);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            assert (e.kind === kind && e.cyc === cyc) else begin
                failures++;
                $error("FAIL event observed=%s@%0d expected=%s@%0d",
                       kind.name(), cyc, e.kind.name(), e.cyc);
            end
        end
    endtask

    task automatic check_val(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_level"},   btn_level,   1'b0);
        check_val({tag, "_press"},   btn_press,   1'b0);
        check_val({tag, "_release"}, btn_release, 1'b0);
        check_val({tag, "_long"},    long_press,  1'b0);
        check_val({tag, "_rst_req"}, rst_req,     1'b0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: every strobe / rst_req edge must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (btn_press || btn_release) begin
                checks++;
                assert (!(btn_press && btn_release)) else begin
                    failures++;
                    $error("FAIL press_release_overlap observed=11 expected=not_both");
                end
            end
            if (btn_press)            check_event(EV_PRESS);
            if (btn_release)          check_event(EV_RELEASE);
            if (long_press)           check_event(EV_LONG);
            if (rst_req && !req_prev) check_event(EV_REQ_ON);
            if (!rst_req && req_prev) check_event(EV_REQ_OFF);
        end
        req_prev <= rst ? 1'b0 : rst_req;
    end

    initial begin
        int p;
        int r;
        rst    = 1'b1;
        btn_in = 1'b0;
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;
        tick(3);

        // Glitches of 3 and STABLE cycles are rejected.
        btn_in = 1'b1; tick(3); btn_in = 1'b0; tick(8);
        check_val("glitch3_level", btn_level, 1'b0);
        btn_in = 1'b1; tick(STABLE); btn_in = 1'b0; tick(8);
        check_val("glitch4_level", btn_level, 1'b0);

        // Press and hold: press, long press, stretched request.
        btn_in = 1'b1;
        p = cyc + LAT;
        push_ev(EV_PRESS,   p);
        push_ev(EV_LONG,    p + HOLD);
        push_ev(EV_REQ_ON,  p + HOLD + 1);
        push_ev(EV_REQ_OFF, p + HOLD + 1 + REQ);
        tick(LAT - 1);
        check_val("pre_press_level", btn_level, 1'b0);
        tick(1);
        check_val("press_level", btn_level, 1'b1);
        tick(30);
        check_val("hold_level", btn_level, 1'b1);
        check_val("hold_rst_req", rst_req, 1'b0);

        // Bounce low for 2 cycles while pressed: nothing fires.
        btn_in = 1'b0; tick(2); btn_in = 1'b1; tick(12);
        check_val("bounce_level", btn_level, 1'b1);

        // Release, then a fresh press with its own long press.
        btn_in = 1'b0;
        push_ev(EV_RELEASE, cyc + LAT);
        tick(LAT + 1);
        check_val("release_level", btn_level, 1'b0);
        btn_in = 1'b1;
        p = cyc + LAT;
        push_ev(EV_PRESS,   p);
        push_ev(EV_LONG,    p + HOLD);
        push_ev(EV_REQ_ON,  p + HOLD + 1);
        push_ev(EV_REQ_OFF, p + HOLD + 1 + REQ);
        tick(22);
        check_val("repress_level", btn_level, 1'b1);
        btn_in = 1'b0;
        push_ev(EV_RELEASE, cyc + LAT);
        tick(LAT + 1);

        // Async reset in WAIT_HI, button still high: full restart.
        btn_in = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        check_all_zero("rst_wait_hi");
        tick(2);
        rst = 1'b0;
        r = cyc;
        p = r + LAT;
        push_ev(EV_PRESS,  p);
        push_ev(EV_LONG,   p + HOLD);
        push_ev(EV_REQ_ON, p + HOLD + 1);
        tick(LAT - 1);
        check_val("restart_pre_level", btn_level, 1'b0);
        tick(p + HOLD + 2 - cyc);
        check_val("mid_req_rst_req", rst_req, 1'b1);
        check_val("mid_req_level", btn_level, 1'b1);

        // Async reset while rst_req is active aborts it at once.
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid_req");
        btn_in = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(12);
        check_all_zero("after_rst");

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL missing_events observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
